// File: rtl/chan_pkg.sv
// Shared definitions for the channel fabric: arbiter latency, destination index
// type and the pointer-wrap helper used by channel FIFOs.
package chan_pkg;

  // Cycles from the arbiter sampling ready to its valid reacting.
  localparam int CHAN_ARB_LATENCY = 2;

  typedef logic [7:0] chan_idx_t;

  // Advance a FIFO pointer, wrapping from depth-1 back to 0 (depth need not be a power of two).
  function automatic int unsigned chan_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/chan_sync_fifo.sv
// Single-clock show-ahead FIFO: register array, wrapping pointers and occupancy count.
// push and pop arrive pre-qualified; the caller guarantees push is never issued when full without pop.
module chan_sync_fifo
  import chan_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int LOG_D = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [LOG_D-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage is deliberately not reset; outVld gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PW'(chan_wrap_inc(int'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= PW'(chan_wrap_inc(int'(rd_ptr), DEPTH));
      case ({push, pop})
        2'b10:   count <= count + LOG_D'(1);
        2'b01:   count <= count - LOG_D'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == LOG_D'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/channel_dst_buffer.sv
// Destination-side ingress buffer behind the channel arbiter, one per destination.
// Optional statistics (hwm_o, dropCnt_o) are built when CHAN_DST_BUF_STATS_EN is defined.
module channel_dst_buffer
  import chan_pkg::*;
#(
  parameter int        N      = 2,
  parameter chan_idx_t DST_ID = '0,
  parameter int        WIDTH  = 64,
  parameter int        DEPTH  = 8,
  parameter int        SKID   = CHAN_ARB_LATENCY,
  parameter int        LOG_D  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     dstVld_i,
  input  logic [WIDTH-1:0] dstDat_i,
  output logic             dstRdy_o,
  output logic             outVld_o,
  output logic [WIDTH-1:0] outDat_o,
  input  logic             outRdy_i,
  output logic [LOG_D-1:0] count_o,
  output logic             ovf_o
`ifdef CHAN_DST_BUF_STATS_EN
  ,
  output logic [LOG_D-1:0] hwm_o,
  output logic [15:0]      dropCnt_o
`endif
);

  // Handshakes: on the output side a beat moves on a clock edge where outVld_o and
  // outRdy_i are both high, and outDat_o is held while outVld_o=1 and outRdy_i=0.
  // On the arbiter side valid does not wait for ready: dstRdy_o is a credit the
  // arbiter samples, and up to SKID beats may still arrive after it drops.

  localparam int DST_SEL   = int'(DST_ID);
  localparam int RDY_LIMIT = DEPTH - SKID;

  logic push_req;
  logic push_acc;
  logic pop;
  logic drop;
  logic full;
  logic empty;
  logic unused_vld;

  assign push_req   = dstVld_i[DST_SEL];
  assign unused_vld = ^dstVld_i;
  assign pop        = outVld_o & outRdy_i;
  // A full FIFO still accepts when a beat leaves in the same cycle.
  assign push_acc   = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  chan_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LOG_D (LOG_D)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push_acc),
    .pop     (pop),
    .wr_data (dstDat_i),
    .rd_data (outDat_o),
    .count   (count_o),
    .full    (full),
    .empty   (empty)
  );

  assign outVld_o = ~empty;
  // Free space must exceed SKID: the in-flight beats plus this cycle's beat always fit.
  assign dstRdy_o = (count_o < LOG_D'(RDY_LIMIT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_o <= 1'b0;
    else if (drop) ovf_o <= 1'b1;
  end

`ifdef CHAN_DST_BUF_STATS_EN
  logic [LOG_D-1:0] count_nxt;

  always_comb begin
    count_nxt = count_o;
    case ({push_acc, pop})
      2'b10:   count_nxt = count_o + LOG_D'(1);
      2'b01:   count_nxt = count_o - LOG_D'(1);
      default: count_nxt = count_o;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hwm_o     <= '0;
      dropCnt_o <= '0;
    end else begin
      if (count_nxt > hwm_o) hwm_o <= count_nxt;
      if (drop && dropCnt_o != 16'hFFFF) dropCnt_o <= dropCnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_channel_dst_buffer.sv
// Directed bench for channel_dst_buffer (DST_ID=1, DEPTH=8, SKID=2) with an
// expected-data queue drained by an independent output monitor.
module tb_channel_dst_buffer;
  localparam int N     = 2;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int SKID  = 2;
  localparam int LOG_D = $clog2(DEPTH + 1);

  logic             clk;
  logic             rstn;
  logic [N-1:0]     dstVld_i;
  logic [WIDTH-1:0] dstDat_i;
  logic             dstRdy_o;
  logic             outVld_o;
  logic [WIDTH-1:0] outDat_o;
  logic             outRdy_i;
  logic [LOG_D-1:0] count_o;
  logic             ovf_o;
`ifdef CHAN_DST_BUF_STATS_EN
  logic [LOG_D-1:0] hwm_o;
  logic [15:0]      dropCnt_o;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  channel_dst_buffer #(
    .N(N), .DST_ID(8'd1), .WIDTH(WIDTH), .DEPTH(DEPTH), .SKID(SKID), .LOG_D(LOG_D)
  ) dut (
    .clk(clk), .rstn(rstn), .dstVld_i(dstVld_i), .dstDat_i(dstDat_i), .dstRdy_o(dstRdy_o),
    .outVld_o(outVld_o), .outDat_o(outDat_o), .outRdy_i(outRdy_i), .count_o(count_o),
    .ovf_o(ovf_o)
`ifdef CHAN_DST_BUF_STATS_EN
    , .hwm_o(hwm_o), .dropCnt_o(dropCnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstn && outVld_o && outRdy_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h, expected no beat at %0t", outDat_o, $time);
      end else begin
        check("pop_data", outDat_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    exp_q.delete();
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_outvld", 64'(outVld_o), 64'd0);
    check("rst_dstrdy", 64'(dstRdy_o), 64'd1);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    next_cycle();
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn     = 1'b0;
    dstVld_i = '0;
    dstDat_i = '0;
    outRdy_i = 1'b0;
    apply_reset();

    // Foreign valid bit is ignored.
    for (int i = 0; i < 5; i++) begin
      dstVld_i = 2'b01;
      dstDat_i = 64'hDEAD;
      @(negedge clk);
      next_cycle();
      check("foreign_count", 64'(count_o), 64'd0);
      check("foreign_outvld", 64'(outVld_o), 64'd0);
    end
    dstVld_i = 2'b00;

    // Fill: ready drops at count 6, two skid beats land, count tops out at 8.
    for (int i = 0; i < 8; i++) begin
      dstVld_i = 2'b10;
      dstDat_i = 64'hA000 + 64'(i);
      exp_q.push_back(64'hA000 + 64'(i));
      @(negedge clk);
      check("fill_count", 64'(count_o), 64'(i));
      check("fill_dstrdy", 64'(dstRdy_o), (i < 6) ? 64'd1 : 64'd0);
      next_cycle();
    end
    dstVld_i = 2'b00;
    @(negedge clk);
    check("full_count", 64'(count_o), 64'd8);
    check("full_dstrdy", 64'(dstRdy_o), 64'd0);
    check("full_ovf", 64'(ovf_o), 64'd0);
    check("full_outvld", 64'(outVld_o), 64'd1);
    check("full_head", outDat_o, 64'hA000);
`ifdef CHAN_DST_BUF_STATS_EN
    check("full_hwm", 64'(hwm_o), 64'd8);
`endif
    next_cycle();

    // Push and pop together at full: accepted, count holds, head advances.
    dstVld_i = 2'b10;
    dstDat_i = 64'hA008;
    outRdy_i = 1'b1;
    exp_q.push_back(64'hA008);
    @(negedge clk);
    check("pp_count_before", 64'(count_o), 64'd8);
    next_cycle();
    dstVld_i = 2'b00;
    outRdy_i = 1'b0;
    @(negedge clk);
    check("pp_count", 64'(count_o), 64'd8);
    check("pp_head", outDat_o, 64'hA001);
    check("pp_ovf", 64'(ovf_o), 64'd0);
    next_cycle();

    // Overflow: a ninth beat with no pop is dropped and sets the sticky flag.
    dstVld_i = 2'b10;
    dstDat_i = 64'hBAD;
    @(negedge clk);
    check("ovf_before", 64'(ovf_o), 64'd0);
    next_cycle();
    dstVld_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_sticky", 64'(ovf_o), 64'd1);
      check("ovf_count", 64'(count_o), 64'd8);
      check("ovf_head", outDat_o, 64'hA001);
      next_cycle();
    end
`ifdef CHAN_DST_BUF_STATS_EN
    check("ovf_dropcnt", 64'(dropCnt_o), 64'd1);
`endif
    apply_reset();

    // Streaming across pointer wrap: count never exceeds 1, no gaps after first beat.
    outRdy_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dstVld_i = 2'b10;
      dstDat_i = 64'(i);
      exp_q.push_back(64'(i));
      @(negedge clk);
      check("stream_count", 64'(count_o), (i == 0) ? 64'd0 : 64'd1);
      check("stream_outvld", 64'(outVld_o), (i == 0) ? 64'd0 : 64'd1);
      check("stream_dstrdy", 64'(dstRdy_o), 64'd1);
      next_cycle();
    end
    dstVld_i = 2'b00;
    @(negedge clk);
    check("stream_tail_count", 64'(count_o), 64'd1);
    next_cycle();
    @(negedge clk);
    check("stream_drained", 64'(count_o), 64'd0);
    check("stream_q_empty", 64'(exp_q.size()), 64'd0);
    outRdy_i = 1'b0;
    next_cycle();

    // Reset mid-operation with five beats stored.
    for (int i = 0; i < 5; i++) begin
      dstVld_i = 2'b10;
      dstDat_i = 64'h50 + 64'(i);
      next_cycle();
    end
    dstVld_i = 2'b00;
    @(negedge clk);
    check("pre_rst_count", 64'(count_o), 64'd5);
    next_cycle();
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_count", 64'(count_o), 64'd0);
    check("async_rst_outvld", 64'(outVld_o), 64'd0);
    check("async_rst_dstrdy", 64'(dstRdy_o), 64'd1);
`ifdef CHAN_DST_BUF_STATS_EN
    check("async_rst_hwm", 64'(hwm_o), 64'd0);
`endif
    next_cycle();
    rstn     = 1'b1;
    outRdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_outvld", 64'(outVld_o), 64'd0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/channel_dst_buffer.md
Name: channel_dst_buffer

Overview:
- Destination-side ingress buffer, one instance per destination port, placed directly downstream of the channel arbiter.
- Picks its own bit out of the arbiter's one-hot valid vector and captures beats from the broadcast data bus into a FIFO.
- Generates the destination ready that feeds back to the arbiter, with enough margin to absorb the arbiter's in-flight beats.
- Presents buffered beats to the destination module on a standard valid/ready interface.

Parameters:
- N, 2, number of destinations; width of the arbiter valid vector.
- DST_ID, 0, index of this destination within the valid vector (0..N-1).
- WIDTH, 64, data width.
- DEPTH, 8, FIFO entries; any integer >= SKID+2, not restricted to powers of two.
- SKID, 2, maximum beats the arbiter can still deliver after ready is sampled low; default equals the arbiter's ready-to-valid latency.
- LOG_D, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- dstVld_i  in  N  one-hot valid vector from the arbiter; only bit DST_ID is used
- dstDat_i  in  WIDTH  broadcast data bus from the arbiter
- dstRdy_o  out  1  ready to the arbiter (drives bit DST_ID of its ready vector)
- outVld_o  out  1  beat available to the destination module
- outDat_o  out  WIDTH  head-of-FIFO data
- outRdy_i  in  1  destination module accepts the beat
- count_o  out  LOG_D  current occupancy
- ovf_o  out  1  sticky overflow error flag

Behaviour:
Reset:
- Reset asserted: count=0, both pointers=0, ovf_o=0, outVld_o=0, dstRdy_o=1 (empty FIFO satisfies the ready rule).
- outDat_o after reset is don't-care; storage is not reset.
- Reset mid-operation discards all stored beats immediately.

Push and pop:
- push = dstVld_i[DST_ID].
- pop = outVld_o & outRdy_i.
- Push is accepted when count<DEPTH, or when count==DEPTH and pop occurs in the same cycle.
- Accepted push: mem[wrPtr] <= dstDat_i; wrPtr advances.
- Pop: rdPtr advances.
- Both pointers wrap explicitly from DEPTH-1 to 0.
- count update: push only +1; pop only -1; push and pop together: unchanged.

Output side:
- Show-ahead (first-word-fall-through) output: outVld_o = (count!=0), outDat_o = mem[rdPtr].
- Push-to-outVld latency: 1 cycle, since data lands in the register array first. There is no combinational path from input to output.
- outDat_o holds stable while outVld_o=1 and outRdy_i=0.

Ready generation:
- dstRdy_o = ((DEPTH - count) > SKID), computed from registered count only.
- Rationale: the SKID beats granted on earlier ready cycles, plus one beat for the current cycle, always fit.
- Pops only increase free space, so the rule is safe.

Overflow:
- A push arriving while count==DEPTH with no simultaneous pop is dropped.
- The dropped beat sets ovf_o=1 on the next edge; ovf_o stays set until reset.
- This case can only occur if the arbiter violates the SKID contract.

Other rules:
- Push and pop on an empty FIFO in the same cycle is not possible, because outVld_o=0.
- A push to an empty FIFO is stored and becomes visible next cycle.
- Bits of dstVld_i other than DST_ID are ignored entirely.

Optional Feature:
- Macro: CHAN_DST_BUF_STATS_EN.
- Defined: adds output hwm_o [LOG_D] and output dropCnt_o [16].
  - hwm_o is the high-water mark of count, updated whenever the next count exceeds hwm_o.
  - dropCnt_o increments on every dropped push and saturates at 16'hFFFF.
  - Both reset to 0.
- Not defined: neither port nor the logic behind them exists; all other behaviour is identical.

Decomposition:
- Package chan_pkg holds:
  - localparam CHAN_ARB_LATENCY = 2, the default for SKID;
  - typedef chan_idx_t for destination indices;
  - a function chan_wrap_inc(ptr, depth) for pointer wrap.
- One natural sub-module: chan_sync_fifo.
  - Contains the register array, pointers, count, full and empty.
  - channel_dst_buffer wraps it and adds valid-bit selection, ready generation, overflow and stats.

Test Plan:
1. Fill at default parameters (DEPTH=8, SKID=2, DST_ID=1):
   - Stimulus: dstVld_i=2'b10 every cycle, outRdy_i=0.
   - Required: dstRdy_o drops when count reaches 6; count tops out at 8 after two skid beats; ovf_o stays 0; outDat_o equals the first beat.
2. Foreign valid ignored:
   - Stimulus: dstVld_i=2'b01 with data 64'hDEAD for 5 cycles.
   - Required: count stays 0 and outVld_o stays 0.
3. Overflow:
   - Stimulus: force a 9th push with the FIFO full and outRdy_i=0.
   - Required: beat dropped, ovf_o=1 from the next cycle until reset, count=8, head data unchanged.
4. Streaming across pointer wrap:
   - Stimulus: push 20 beats with values 0..19 while outRdy_i=1 every cycle.
   - Required: output sequence 0..19 in order with no gaps after the first 1-cycle latency; count never exceeds 1; dstRdy_o stays 1.
5. Simultaneous push and pop at full:
   - Stimulus: push and pop in the same cycle with count=8.
   - Required: push accepted, count stays 8, next head is the old second entry, ovf_o=0.
6. Reset mid-operation:
   - Stimulus: assert rstn=0 asynchronously with count=5.
   - Required: count=0, outVld_o=0 and dstRdy_o=1 immediately; no stale beat appears after reset is released.
   - With CHAN_DST_BUF_STATS_EN defined, hwm_o=0 after reset.
